// File: rtl/pueo_command_encoder.sv
// -----------------------------------------------------------------------------
// pueo_command_encoder
//
// Turf-side command encoder. Collects run commands, mode1 specials, mode1
// stream bytes (command or firmware stream) and trigger requests, and packs
// them into one 32-bit command word per slot of SLOT_LEN sysclk cycles. The
// word is registered on the last cycle of the slot (the load cycle) and shows
// up on command_o together with a one-cycle command_valid_o strobe on the
// first cycle of the following slot.
//
// Word layout:
//   [31]    1 = no message (runcmd idle and mode1 idle), 0 = message carried
//   [30:28] 0
//   [27:26] runcmd   (00 none, 01 DO_SYNC, 10 RESET, 11 STOP)
//   [25:24] mode1 type
//   [23:16] mode1 data
//   [15]    trigger present
//   [14]    0
//   [13:0]  trigger time (0 when no trigger)
//
// Ports:
//   sysclk_i, sysrst_n_i          clock / async active-low reset
//   rundosync_i, runrst_i,
//   runstop_i                     run command request pulses
//   cmdproc_rst_i                 mode1 special 0x01 request pulse
//   fw_mark_i[1:0]                mode1 specials 0x02 / 0x03 request pulses
//   cmd_tdata/tvalid/tlast/tready mode1 command byte stream (AXI-S style)
//   fw_tdata/tvalid/tready        firmware byte stream (AXI-S style)
//   fw_mode_i                     1 = serve fw stream, 0 = serve cmd stream
//   trig_time_i, trig_valid_i     trigger request
//   trig_drop_o                   pulse: a trigger request was discarded
//   command_o, command_valid_o    command word and its strobe
// -----------------------------------------------------------------------------
module pueo_command_encoder #(
  parameter int SLOT_LEN = 8,
  parameter     DEBUG    = "TRUE"
) (
  input  logic        sysclk_i,
  input  logic        sysrst_n_i,

  input  logic        rundosync_i,
  input  logic        runrst_i,
  input  logic        runstop_i,
  input  logic        cmdproc_rst_i,
  input  logic [1:0]  fw_mark_i,

  input  logic [7:0]  cmd_tdata,
  input  logic        cmd_tvalid,
  input  logic        cmd_tlast,
  output logic        cmd_tready,

  input  logic [7:0]  fw_tdata,
  input  logic        fw_tvalid,
  output logic        fw_tready,

  input  logic        fw_mode_i,

  input  logic [13:0] trig_time_i,
  input  logic        trig_valid_i,
  output logic        trig_drop_o,

  output logic [31:0] command_o,
  output logic        command_valid_o
);

  localparam int              CntW    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SLOT_LEN - 1);

  localparam logic [1:0] RunNone  = 2'b00;
  localparam logic [1:0] RunSync  = 2'b01;
  localparam logic [1:0] RunReset = 2'b10;
  localparam logic [1:0] RunStop  = 2'b11;

  localparam logic [31:0] IdleWord = 32'h8000_0000;

  // Slot counter and pending request flags
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync_q, sync_d;
  logic            rst_q, rst_d;
  logic            stop_q, stop_d;
  logic            cprst_q, cprst_d;
  logic            marka_q, marka_d;
  logic            markb_q, markb_d;
  logic            trig_q, trig_d;
  logic [13:0]     trig_time_q, trig_time_d;
  logic            drop_q, drop_d;

  // Output registers
  logic [31:0]     command_q, command_d;
  logic            valid_q, valid_d;

  // Load-cycle word assembly
  logic            load;
  logic            special_pend;
  logic            cmd_beat, fw_beat;
  logic [1:0]      runcmd;
  logic            take_rst, take_stop, take_sync;
  logic [1:0]      m1_type;
  logic [7:0]      m1_data;
  logic            take_cprst, take_marka, take_markb;
  logic            msg;
  logic            trig_accept;
  logic [31:0]     word;

  always_comb begin
    load         = (cnt_q == CntLast);
    special_pend = cprst_q | marka_q | markb_q;

    // A stream byte can only ride in a slot whose mode1 field is not already
    // claimed by a special; tready is deliberately independent of tvalid.
    cmd_tready = load & ~special_pend & ~fw_mode_i;
    fw_tready  = load & ~special_pend &  fw_mode_i;
    cmd_beat   = cmd_tvalid & cmd_tready;
    fw_beat    = fw_tvalid & fw_tready;

    runcmd    = RunNone;
    take_rst  = 1'b0;
    take_stop = 1'b0;
    take_sync = 1'b0;
    if (rst_q) begin
      runcmd   = RunReset;
      take_rst = load;
    end else if (stop_q) begin
      runcmd    = RunStop;
      take_stop = load;
    end else if (sync_q) begin
      runcmd    = RunSync;
      take_sync = load;
    end

    m1_type    = 2'b00;
    m1_data    = 8'h00;
    take_cprst = 1'b0;
    take_marka = 1'b0;
    take_markb = 1'b0;
    if (cprst_q) begin
      m1_data    = 8'h01;
      take_cprst = load;
    end else if (marka_q) begin
      m1_data    = 8'h02;
      take_marka = load;
    end else if (markb_q) begin
      m1_data    = 8'h03;
      take_markb = load;
    end else if (cmd_beat) begin
      m1_type = cmd_tlast ? 2'b11 : 2'b01;
      m1_data = cmd_tdata;
    end else if (fw_beat) begin
      m1_type = 2'b11;
      m1_data = fw_tdata;
    end

    msg  = (runcmd != RunNone) | (m1_type != 2'b00) | (m1_data != 8'h00);
    word = {~msg, 3'b000, runcmd, m1_type, m1_data,
            trig_q, 1'b0, (trig_q ? trig_time_q : 14'h0000)};

    cnt_d = load ? '0 : cnt_q + 1'b1;

    // New requests are OR-ed in after the consumed flag is cleared, so a
    // request landing on the load cycle survives into the next slot.
    rst_d   = (rst_q   & ~take_rst)   | runrst_i;
    stop_d  = (stop_q  & ~take_stop)  | runstop_i;
    sync_d  = (sync_q  & ~take_sync)  | rundosync_i;
    cprst_d = (cprst_q & ~take_cprst) | cmdproc_rst_i;
    marka_d = (marka_q & ~take_marka) | fw_mark_i[0];
    markb_d = (markb_q & ~take_markb) | fw_mark_i[1];

    // A trigger on the load cycle replaces the one being sent, so it is
    // accepted rather than dropped.
    trig_accept = trig_valid_i & (~trig_q | load);
    trig_d      = trig_accept | (trig_q & ~load);
    trig_time_d = trig_accept ? trig_time_i : trig_time_q;
    drop_d      = trig_valid_i & trig_q & ~load;

    command_d = load ? word : command_q;
    valid_d   = load;
  end

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      cnt_q       <= '0;
      sync_q      <= 1'b0;
      rst_q       <= 1'b0;
      stop_q      <= 1'b0;
      cprst_q     <= 1'b0;
      marka_q     <= 1'b0;
      markb_q     <= 1'b0;
      trig_q      <= 1'b0;
      trig_time_q <= 14'h0000;
      drop_q      <= 1'b0;
      command_q   <= IdleWord;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      rst_q       <= rst_d;
      stop_q      <= stop_d;
      cprst_q     <= cprst_d;
      marka_q     <= marka_d;
      markb_q     <= markb_d;
      trig_q      <= trig_d;
      trig_time_q <= trig_time_d;
      drop_q      <= drop_d;
      command_q   <= command_d;
      valid_q     <= valid_d;
    end
  end

  assign command_o       = command_q;
  assign command_valid_o = valid_q;
  assign trig_drop_o     = drop_q;

  // Debug attach point: the vendor ILA wrapper binds to cnt_q and the
  // pending flags inside this block when DEBUG is "TRUE".
  if (DEBUG == "TRUE") begin : g_ila
  end

endmodule

// File: tb/tb_pueo_command_encoder.sv
module tb_pueo_command_encoder;

  localparam int SL = 8;

  logic        sysclk = 1'b0;
  logic        sysrst_n;
  logic        rundosync, runrst, runstop, cmdproc_rst;
  logic [1:0]  fw_mark;
  logic [7:0]  cmd_tdata;
  logic        cmd_tvalid, cmd_tlast, cmd_tready;
  logic [7:0]  fw_tdata;
  logic        fw_tvalid, fw_tready;
  logic        fw_mode;
  logic [13:0] trig_time;
  logic        trig_valid, trig_drop;
  logic [31:0] command;
  logic        command_valid;

  pueo_command_encoder #(.SLOT_LEN(SL), .DEBUG("TRUE")) dut (
    .sysclk_i        (sysclk),
    .sysrst_n_i      (sysrst_n),
    .rundosync_i     (rundosync),
    .runrst_i        (runrst),
    .runstop_i       (runstop),
    .cmdproc_rst_i   (cmdproc_rst),
    .fw_mark_i       (fw_mark),
    .cmd_tdata       (cmd_tdata),
    .cmd_tvalid      (cmd_tvalid),
    .cmd_tlast       (cmd_tlast),
    .cmd_tready      (cmd_tready),
    .fw_tdata        (fw_tdata),
    .fw_tvalid       (fw_tvalid),
    .fw_tready       (fw_tready),
    .fw_mode_i       (fw_mode),
    .trig_time_i     (trig_time),
    .trig_valid_i    (trig_valid),
    .trig_drop_o     (trig_drop),
    .command_o       (command),
    .command_valid_o (command_valid)
  );

  always #4 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;
  int ph    = 0;   // cycles since reset release, modulo SL

  typedef struct {
    bit        rs, st, sy, cp;
    bit [1:0]  mk;
    bit        tv;
    bit [13:0] tt;
    bit        sv;
    bit [7:0]  sd;
    bit        sl;
    bit        fwm;
    bit [31:0] exp_w;
    bit        exp_rdy;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
    ph = (ph + 1) % SL;
  endtask

  task automatic idle_inputs();
    rundosync = 0; runrst = 0; runstop = 0; cmdproc_rst = 0; fw_mark = 2'b00;
    cmd_tdata = 8'h00; cmd_tvalid = 0; cmd_tlast = 0;
    fw_tdata = 8'h00; fw_tvalid = 0; fw_mode = 0;
    trig_time = 14'h0; trig_valid = 0;
  endtask

  task automatic do_reset();
    sysrst_n = 0;
    idle_inputs();
    repeat (2) @(posedge sysclk);
    #1;
    sysrst_n = 1;
    ph = 0;
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < SL && ph != p; i++) tick();
  endtask

  task automatic clear_pulses();
    rundosync = 0; runrst = 0; runstop = 0; cmdproc_rst = 0; fw_mark = 2'b00; trig_valid = 0;
  endtask

  // Random-phase reference model state
  bit          rq[6];    // 0 reset, 1 stop, 2 sync, 3 cmdproc rst, 4 mark A, 5 mark B
  bit          mhas;
  logic [13:0] mt;
  logic [31:0] m_cmd;
  bit          m_valid, m_drop;

  logic [31:0] exp3[3];
  logic [7:0]  dat3[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    sysrst_n = 0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_command", command, 32'h8000_0000);
    chk1("rst_valid", command_valid, 1'b0);
    chk1("rst_cmd_tready", cmd_tready, 1'b0);
    chk1("rst_fw_tready", fw_tready, 1'b0);
    chk1("rst_drop", trig_drop, 1'b0);

    // ---------------- single-slot vector table ----------------
    //            rs st sy cp mk    tv tt        sv sd     sl fwm exp_w          rdy
    vecs[0]  = '{0, 0, 0, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h8000_0000, 1};
    vecs[1]  = '{1, 0, 0, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0800_0000, 1};
    vecs[2]  = '{0, 1, 0, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0C00_0000, 1};
    vecs[3]  = '{0, 0, 1, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0400_0000, 1};
    vecs[4]  = '{1, 1, 0, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0800_0000, 1};
    vecs[5]  = '{0, 1, 1, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0C00_0000, 1};
    vecs[6]  = '{0, 0, 0, 1, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0001_0000, 0};
    vecs[7]  = '{0, 0, 0, 0, 2'b01, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0002_0000, 0};
    vecs[8]  = '{0, 0, 0, 0, 2'b10, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0003_0000, 0};
    vecs[9]  = '{0, 0, 0, 0, 2'b11, 0, 14'h0000, 0, 8'h00, 0, 0, 32'h0002_0000, 0};
    vecs[10] = '{0, 0, 0, 0, 2'b00, 0, 14'h0000, 1, 8'hA1, 0, 0, 32'h01A1_0000, 1};
    vecs[11] = '{0, 0, 0, 0, 2'b00, 0, 14'h0000, 1, 8'hC3, 1, 0, 32'h03C3_0000, 1};
    vecs[12] = '{0, 0, 0, 0, 2'b00, 0, 14'h0000, 1, 8'h5A, 0, 1, 32'h035A_0000, 1};
    vecs[13] = '{0, 0, 0, 0, 2'b00, 1, 14'h1234, 0, 8'h00, 0, 0, 32'h8000_9234, 1};
    vecs[14] = '{0, 0, 1, 0, 2'b00, 1, 14'h3FFF, 0, 8'h00, 0, 0, 32'h0400_BFFF, 1};
    vecs[15] = '{0, 1, 0, 1, 2'b00, 0, 14'h0000, 1, 8'hA1, 0, 0, 32'h0C01_0000, 0};
    vecs[16] = '{0, 0, 0, 0, 2'b00, 1, 14'h0000, 0, 8'h00, 0, 0, 32'h8000_8000, 1};
    vecs[17] = '{0, 0, 0, 0, 2'b00, 0, 14'h0000, 0, 8'h00, 0, 1, 32'h8000_0000, 1};
    vecs[18] = '{0, 0, 1, 0, 2'b00, 0, 14'h0000, 1, 8'h0F, 1, 0, 32'h070F_0000, 1};
    vecs[19] = '{1, 0, 0, 0, 2'b10, 1, 14'h2AAA, 0, 8'h00, 0, 0, 32'h0803_AAAA, 0};

    foreach (vecs[i]) begin
      do_reset();
      run_to(3);
      runrst = vecs[i].rs; runstop = vecs[i].st; rundosync = vecs[i].sy;
      cmdproc_rst = vecs[i].cp; fw_mark = vecs[i].mk;
      trig_valid = vecs[i].tv; trig_time = vecs[i].tt;
      tick();
      clear_pulses();
      run_to(SL - 1);
      fw_mode = vecs[i].fwm;
      // the unselected stream always offers a junk byte that must never appear
      if (vecs[i].fwm) begin
        fw_tvalid = vecs[i].sv; fw_tdata = vecs[i].sd;
        cmd_tvalid = 1; cmd_tdata = 8'hEE; cmd_tlast = 1;
      end else begin
        cmd_tvalid = vecs[i].sv; cmd_tdata = vecs[i].sd; cmd_tlast = vecs[i].sl;
        fw_tvalid = 1; fw_tdata = 8'hDD;
      end
      #1;
      chk1($sformatf("vec%0d_sel_tready", i), vecs[i].fwm ? fw_tready : cmd_tready, vecs[i].exp_rdy);
      chk1($sformatf("vec%0d_unsel_tready", i), vecs[i].fwm ? cmd_tready : fw_tready, 1'b0);
      tick();
      cmd_tvalid = 0; fw_tvalid = 0;
      chk($sformatf("vec%0d_word", i), command, vecs[i].exp_w);
      chk1($sformatf("vec%0d_valid", i), command_valid, 1'b1);
    end

    // ---------------- strobe cadence after reset ----------------
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk1($sformatf("cad_valid_c%0d", c), command_valid, (c % SL) == 0);
      if ((c % SL) == 0) chk($sformatf("cad_word_c%0d", c), command, 32'h8000_0000);
    end

    // ---------------- reset + do_sync split over two slots ----------------
    do_reset();
    run_to(3);
    runrst = 1; rundosync = 1;
    tick();
    clear_pulses();
    run_to(SL - 1); tick();
    chk("split_slot0", command, 32'h0800_0000);
    tick();
    chk1("split_strobe_width", command_valid, 1'b0);
    chk("split_hold", command, 32'h0800_0000);
    run_to(SL - 1); tick();
    chk("split_slot1", command, 32'h0400_0000);
    run_to(SL - 1); tick();
    chk("split_slot2", command, 32'h8000_0000);

    // ---------------- request on load cycle deferred; merge ----------------
    do_reset();
    run_to(2);
    runstop = 1; tick(); runstop = 1; tick(); clear_pulses();  // merged
    run_to(SL - 1);
    rundosync = 1;                                           // arrives on load
    tick();
    clear_pulses();
    chk("load_req_slot0", command, 32'h0C00_0000);
    run_to(SL - 1); tick();
    chk("load_req_slot1", command, 32'h0400_0000);
    run_to(SL - 1); tick();
    chk("merge_slot2", command, 32'h8000_0000);

    // ---------------- three-byte cmd stream ----------------
    do_reset();
    exp3[0] = 32'h01A1_0000; exp3[1] = 32'h01B2_0000; exp3[2] = 32'h03C3_0000;
    dat3[0] = 8'hA1; dat3[1] = 8'hB2; dat3[2] = 8'hC3;
    begin
      int k;
      k = 0;
      cmd_tvalid = 1; cmd_tdata = dat3[0]; cmd_tlast = 0;
      for (int c = 0; c < 3 * SL; c++) begin
        chk1($sformatf("strm_tready_c%0d", c), cmd_tready, ph == SL - 1);
        if (ph == SL - 1) begin
          tick();
          chk($sformatf("strm_word%0d", k), command, exp3[k]);
          k++;
          if (k < 3) begin
            cmd_tdata = dat3[k]; cmd_tlast = (k == 2);
          end else begin
            cmd_tvalid = 0; cmd_tlast = 0;
          end
        end else begin
          tick();
        end
      end
    end

    // ---------------- special blocks stream byte ----------------
    do_reset();
    cmd_tvalid = 1; cmd_tdata = 8'h77; cmd_tlast = 0;
    run_to(3);
    cmdproc_rst = 1; tick(); clear_pulses();
    run_to(SL - 1);
    chk1("spec_block_tready", cmd_tready, 1'b0);
    tick();
    chk("spec_word", command, 32'h0001_0000);
    run_to(SL - 1);
    chk1("spec_after_tready", cmd_tready, 1'b1);
    tick();
    cmd_tvalid = 0;
    chk("spec_byte_next", command, 32'h0177_0000);

    // ---------------- trigger drop and load-cycle trigger ----------------
    do_reset();
    run_to(2);
    trig_valid = 1; trig_time = 14'h1234; tick();
    trig_valid = 1; trig_time = 14'h0555; tick();
    trig_valid = 0;
    chk1("drop_pulse", trig_drop, 1'b1);
    tick();
    chk1("drop_once", trig_drop, 1'b0);
    run_to(SL - 1);
    trig_valid = 1; trig_time = 14'h0ABC;                    // on load: accepted
    tick();
    trig_valid = 0;
    chk("trig_word0", command, 32'h8000_9234);
    chk1("trig_load_nodrop", trig_drop, 1'b0);
    run_to(SL - 1); tick();
    chk("trig_word1", command, 32'h8000_8ABC);
    run_to(SL - 1); tick();
    chk("trig_cleared", command, 32'h8000_0000);

    // ---------------- fw mode with mark A, then mid-slot reset ----------------
    do_reset();
    fw_mode = 1; fw_tvalid = 1; fw_tdata = 8'h5A;
    run_to(3);
    fw_mark = 2'b01; tick(); clear_pulses();
    run_to(SL - 1); tick();
    chk("fw_mark_word", command, 32'h0002_0000);
    run_to(SL - 1); tick();
    fw_tvalid = 0;
    chk("fw_byte_word", command, 32'h035A_0000);
    run_to(3);
    runstop = 1; trig_valid = 1; trig_time = 14'h0111; tick(); clear_pulses();
    #1;
    sysrst_n = 0;
    #1;
    chk("midrst_command", command, 32'h8000_0000);
    chk1("midrst_valid", command_valid, 1'b0);
    repeat (2) @(posedge sysclk);
    #1;
    sysrst_n = 1;
    ph = 0;
    for (int c = 1; c <= SL; c++) begin
      tick();
      chk1($sformatf("midrst_valid_c%0d", c), command_valid, c == SL);
    end
    chk("midrst_lost", command, 32'h8000_0000);

    // ---------------- randomized run against reference model ----------------
    do_reset();
    foreach (rq[i]) rq[i] = 0;
    mhas = 0; mt = 14'h0; m_cmd = 32'h8000_0000; m_valid = 0; m_drop = 0;
    for (int c = 0; c < 1200; c++) begin
      bit ld, rdy;
      chk($sformatf("rnd_cmd_c%0d", c), command, m_cmd);
      chk1($sformatf("rnd_valid_c%0d", c), command_valid, m_valid);
      chk1($sformatf("rnd_drop_c%0d", c), trig_drop, m_drop);

      runrst      = ($urandom_range(0, 11) == 0);
      runstop     = ($urandom_range(0, 11) == 0);
      rundosync   = ($urandom_range(0, 11) == 0);
      cmdproc_rst = ($urandom_range(0, 15) == 0);
      fw_mark     = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      trig_valid  = ($urandom_range(0, 5) == 0);
      trig_time   = 14'($urandom);
      if ($urandom_range(0, 31) == 0) fw_mode = ~fw_mode;
      cmd_tvalid = 1'($urandom); cmd_tdata = 8'($urandom); cmd_tlast = 1'($urandom);
      fw_tvalid  = 1'($urandom); fw_tdata  = 8'($urandom);
      #1;

      ld  = (ph == SL - 1);
      rdy = ld && !(rq[3] || rq[4] || rq[5]);
      chk1($sformatf("rnd_cmd_tready_c%0d", c), cmd_tready, rdy && !fw_mode);
      chk1($sformatf("rnd_fw_tready_c%0d", c), fw_tready, rdy && fw_mode);

      m_valid = ld;
      if (ld) begin
        int run, ty, da;
        bit keep;
        run = 0; ty = 0; da = 0;
        if (rq[0])      begin run = 2; rq[0] = 0; end
        else if (rq[1]) begin run = 3; rq[1] = 0; end
        else if (rq[2]) begin run = 1; rq[2] = 0; end
        if (rq[3])      begin da = 1; rq[3] = 0; end
        else if (rq[4]) begin da = 2; rq[4] = 0; end
        else if (rq[5]) begin da = 3; rq[5] = 0; end
        else if (fw_mode && fw_tvalid) begin ty = 3; da = int'(fw_tdata); end
        else if (!fw_mode && cmd_tvalid) begin ty = cmd_tlast ? 3 : 1; da = int'(cmd_tdata); end
        keep = (run == 0 && ty == 0 && da == 0);
        m_cmd = (keep ? 32'h8000_0000 : 32'h0) | (32'(run) << 26) | (32'(ty) << 24)
              | (32'(da) << 16) | (mhas ? (32'h8000 | 32'(mt)) : 32'h0);
      end
      begin
        bit still;
        still  = mhas && !ld;
        m_drop = 0;
        if (trig_valid) begin
          if (still) m_drop = 1;
          else begin still = 1; mt = trig_time; end
        end
        mhas = still;
      end
      if (runrst)      rq[0] = 1;
      if (runstop)     rq[1] = 1;
      if (rundosync)   rq[2] = 1;
      if (cmdproc_rst) rq[3] = 1;
      if (fw_mark[0])  rq[4] = 1;
      if (fw_mark[1])  rq[5] = 1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
